// File: rtl/uart_ctrl_pkg.sv
// Shared register map, CON layout and TX sequencer states for the UART controller.
package uart_ctrl_pkg;

  localparam logic [3:0] UART_TXD = 4'h0;
  localparam logic [3:0] UART_RXD = 4'h4;
  localparam logic [3:0] UART_CON = 4'h8;

  localparam int unsigned CON_TX_IE   = 0;
  localparam int unsigned CON_RX_IE   = 1;
  localparam int unsigned CON_TX_FULL = 2;
  localparam int unsigned CON_RX_NE   = 3;
  localparam int unsigned CON_TX_BUSY = 4;
  localparam int unsigned CON_RX_OVR  = 5;
  localparam int unsigned CON_TX_OVF  = 6;
  localparam int unsigned CON_TX_TMO  = 7;

  localparam int unsigned TMO_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  // CON read view, MSB first so it packs directly into rdata[7:0]
  typedef struct packed {
    logic tx_tmo;
    logic tx_ovf;
    logic rx_ovr;
    logic tx_busy;
    logic rx_ne;
    logic tx_full;
    logic rx_ie;
    logic tx_ie;
  } con_reg_t;

endpackage

// File: rtl/uart_ctrl_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-facing UART controller: TX/RX byte FIFOs, TX launch sequencer with busy
// timeout, CON status/control/sticky register and interrupt generation.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned RX_DEPTH     = 4,
  parameter int unsigned BUSY_TIMEOUT = 2047
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_enable,
  input  logic        uart_tx_status,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_status
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUSY_TIMEOUT);

  logic [1:0]       tx_sync;
  logic [1:0]       rx_sync;
  logic             rx_prev;
  logic             tx_status_s;
  logic             rx_strobe;
  logic             wr_txd;
  logic             wr_con;
  logic             rd_rxd;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]       tx_head, rx_head;
  tx_state_e        state, state_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tx_enable_d;
  logic [7:0]       tx_data_d;
  logic             tx_pop;
  logic             tmo_hit;
  logic             tx_ie, rx_ie, rx_ovr, tx_ovf, tx_tmo;
  logic             rx_ovr_set, tx_ovf_set;
  con_reg_t         con;
  logic             unused_wdata;

  assign unused_wdata = ^{wdata[31:8], wdata[4:2]};

  // TX status idles high, RX flag idles low; both cross from the baud domain
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sync <= 2'b11;
      rx_sync <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      tx_sync <= {tx_sync[0], uart_tx_status};
      rx_sync <= {rx_sync[0], uart_rx_status};
      rx_prev <= rx_sync[1];
    end
  end

  assign tx_status_s = tx_sync[1];
  assign rx_strobe   = rx_sync[1] & ~rx_prev;

  assign wr_txd = mem_write & (addr == UART_TXD);
  assign wr_con = mem_write & (addr == UART_CON);
  assign rd_rxd = mem_read  & (addr == UART_RXD);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (sysclk),
    .rst_n (reset_n),
    .push  (wr_txd),
    .pop   (tx_pop),
    .wdata (wdata[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (sysclk),
    .rst_n (reset_n),
    .push  (rx_strobe),
    .pop   (rd_rxd),
    .wdata (uart_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      uart_tx_enable <= 1'b0;
      uart_tx_data   <= '0;
    end else begin
      state          <= state_d;
      tmo_cnt        <= tmo_cnt_d;
      uart_tx_enable <= tx_enable_d;
      uart_tx_data   <= tx_data_d;
    end
  end

  // Launch data and enable are loaded on entry to LAUNCH so they are valid during it
  always_comb begin
    state_d     = state;
    tmo_cnt_d   = tmo_cnt;
    tx_enable_d = 1'b0;
    tx_data_d   = uart_tx_data;
    tx_pop      = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          state_d     = LAUNCH;
          tx_enable_d = 1'b1;
          tx_data_d   = tx_head;
        end
      end
      LAUNCH: begin
        tx_pop    = 1'b1;
        tmo_cnt_d = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_status_s) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt >= TMO_LIMIT) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
        end else if (tmo_cnt != '1) begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_status_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so only true drops raise the sticky flags
  assign rx_ovr_set = rx_strobe & rx_full & ~rd_rxd;
  assign tx_ovf_set = wr_txd & tx_full & ~tx_pop;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ie  <= 1'b0;
      rx_ie  <= 1'b0;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
      tx_tmo <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_con) begin
        tx_ie <= wdata[CON_TX_IE];
        rx_ie <= wdata[CON_RX_IE];
      end
      rx_ovr <= rx_ovr_set | (rx_ovr & ~(wr_con & wdata[CON_RX_OVR]));
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_con & wdata[CON_TX_OVF]));
      tx_tmo <= tmo_hit    | (tx_tmo & ~(wr_con & wdata[CON_TX_TMO]));
      irq    <= (tx_ie & tx_empty & (state == IDLE)) | (rx_ie & ~rx_empty);
    end
  end

  assign con = '{
    tx_tmo:  tx_tmo,
    tx_ovf:  tx_ovf,
    rx_ovr:  rx_ovr,
    tx_busy: (state != IDLE),
    rx_ne:   ~rx_empty,
    tx_full: tx_full,
    rx_ie:   rx_ie,
    tx_ie:   tx_ie
  };

  always_comb begin
    rdata = '0;
    case (addr)
      UART_RXD: if (!rx_empty) rdata = {24'b0, rx_head};
      UART_CON: rdata = {24'b0, con};
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: UART transmitter model plus queue-based
// reference for the TX byte stream and RX FIFO contents.
module tb_uart_ctrl;
  import uart_ctrl_pkg::*;

  localparam int unsigned TXD_N = 4;
  localparam int unsigned RXD_N = 4;
  localparam int unsigned TMO   = 2047;

  logic        sysclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_enable;
  logic        uart_tx_status = 1'b1;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_status = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 sysclk = ~sysclk;

  uart_ctrl #(.TX_DEPTH(TXD_N), .RX_DEPTH(RXD_N), .BUSY_TIMEOUT(TMO)) dut (
    .sysclk         (sysclk),
    .reset_n        (reset_n),
    .addr           (addr),
    .wdata          (wdata),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .rdata          (rdata),
    .irq            (irq),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_enable (uart_tx_enable),
    .uart_tx_status (uart_tx_status),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_status (uart_rx_status)
  );

  // UART transmitter model: logs launched bytes, drops status after fall_dly, raises it busy_dly later
  int         fall_dly = 5;
  int         busy_dly = 20;
  bit         uart_hang = 1'b0;
  bit         uart_active = 1'b0;
  int         uart_cnt = 0;
  logic [7:0] tx_log [$];

  always @(negedge sysclk) begin
    if (uart_tx_enable === 1'b1) begin
      tx_log.push_back(uart_tx_data);
      uart_cnt    = 0;
      uart_active = !uart_hang;
    end else if (uart_active) begin
      uart_cnt++;
      if (uart_cnt == fall_dly) uart_tx_status = 1'b0;
      if (uart_cnt >= fall_dly + busy_dly) begin
        uart_tx_status = 1'b1;
        uart_active    = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge sysclk);
      #1;
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1;
    #1;
    d = rdata;
    tick();
    mem_read = 1'b0;
  endtask

  task automatic rx_deliver(input logic [7:0] b, input int hold);
    uart_rx_data = b; uart_rx_status = 1'b1;
    tick(hold);
    uart_rx_status = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    tick(3);
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
    tests_run++; if (uart_tx_enable !== 1'b0 || uart_tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_out: got en=%b data=%h want 0/00", uart_tx_enable, uart_tx_data); end
    peek(UART_CON, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_con: got %h want 0", d); end
    peek(UART_RXD, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_rxd: got %h want 0", d); end
    reset_n = 1'b1;
    tick(2);
    peek(UART_CON, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL post_reset_con: got %h want 0", d); end
    peek(UART_TXD, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL txd_read: got %h want 0", d); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    int bad, n;
    tx_log.delete();
    fall_dly = 700; busy_dly = 10400;
    bus_write(UART_TXD, 32'h55);
    tests_run++; if (uart_tx_enable !== 1'b0) begin tests_failed++; $display("FAIL enable_cycle1: got %b want 0", uart_tx_enable); end
    tick();
    tests_run++; if (uart_tx_enable !== 1'b1 || uart_tx_data !== 8'h55) begin tests_failed++; $display("FAIL enable_cycle2: got en=%b data=%h want 1/55", uart_tx_enable, uart_tx_data); end
    tick();
    tests_run++; if (uart_tx_enable !== 1'b0) begin tests_failed++; $display("FAIL enable_width: got %b want 0", uart_tx_enable); end
    bad = 0; n = 0;
    while (uart_active && n < 20000) begin
      peek(UART_CON, d);
      if (d[CON_TX_BUSY] !== 1'b1) bad++;
      tick(); n++;
    end
    tests_run++; if (bad != 0 || uart_active) begin tests_failed++; $display("FAIL busy_hold: got %0d idle samples (active=%b) want 0", bad, uart_active); end
    n = 0;
    peek(UART_CON, d);
    while (d[CON_TX_BUSY] === 1'b1 && n < 10) begin tick(); n++; peek(UART_CON, d); end
    tests_run++; if (n != 3) begin tests_failed++; $display("FAIL busy_release: got %0d cycles want 3", n); end
    tests_run++; if (tx_log.size() != 1 || tx_log[0] !== 8'h55) begin tests_failed++; $display("FAIL single_log: got %0d bytes want 1 of 55", tx_log.size()); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    int n;
    int accepted;
    tx_log.delete();
    fall_dly = 5; busy_dly = 200;
    for (int i = 1; i <= 6; i++) bus_write(UART_TXD, 32'(i));
    accepted = TXD_N + 1;
    peek(UART_CON, d);
    tests_run++; if (d[CON_TX_OVF] !== 1'b1 || d[CON_TX_FULL] !== 1'b1) begin tests_failed++; $display("FAIL tx_ovf_set: got ovf=%b full=%b want 1/1", d[CON_TX_OVF], d[CON_TX_FULL]); end
    bus_write(UART_CON, 32'h40);
    peek(UART_CON, d);
    tests_run++; if (d[CON_TX_OVF] !== 1'b0) begin tests_failed++; $display("FAIL tx_ovf_clear: got %b want 0", d[CON_TX_OVF]); end
    n = 0;
    peek(UART_CON, d);
    while ((tx_log.size() < accepted || d[CON_TX_BUSY] === 1'b1) && n < 5000) begin tick(); n++; peek(UART_CON, d); end
    tests_run++; if (tx_log.size() != accepted) begin tests_failed++; $display("FAIL tx_ovf_count: got %0d want %0d", tx_log.size(), accepted); end
    for (int i = 0; i < accepted && i < tx_log.size(); i++) begin
      tests_run++; if (tx_log[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL tx_ovf_byte%0d: got %h want %h", i, tx_log[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    rx_deliver(8'hA3, 650);
    peek(UART_CON, d);
    tests_run++; if (d[CON_RX_NE] !== 1'b1 || d[CON_RX_OVR] !== 1'b0) begin tests_failed++; $display("FAIL rx_ne: got ne=%b ovr=%b want 1/0", d[CON_RX_NE], d[CON_RX_OVR]); end
    bus_read(UART_RXD, d);
    tests_run++; if (d !== 32'hA3) begin tests_failed++; $display("FAIL rx_data: got %h want a3", d); end
    peek(UART_CON, d);
    tests_run++; if (d[CON_RX_NE] !== 1'b0) begin tests_failed++; $display("FAIL rx_single: got ne=%b want 0", d[CON_RX_NE]); end
    bus_read(UART_RXD, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rx_empty_read: got %h want 0", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  q [$];
    logic [7:0]  b;
    logic [31:0] exp;
    bit          ovr_exp;
    ovr_exp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      rx_deliver(b, 40);
      if (q.size() < RXD_N) q.push_back(b); else ovr_exp = 1'b1;
    end
    peek(UART_CON, d);
    tests_run++; if (d[CON_RX_OVR] !== ovr_exp || d[CON_RX_NE] !== 1'b1) begin tests_failed++; $display("FAIL rx_ovr_set: got ovr=%b ne=%b want %b/1", d[CON_RX_OVR], d[CON_RX_NE], ovr_exp); end
    for (int i = 0; i < 5; i++) begin
      exp = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'h0;
      bus_read(UART_RXD, d);
      tests_run++; if (d !== exp) begin tests_failed++; $display("FAIL rx_ovr_read%0d: got %h want %h", i, d, exp); end
    end
    bus_write(UART_CON, 32'h20);
    peek(UART_CON, d);
    tests_run++; if (d[CON_RX_OVR] !== 1'b0) begin tests_failed++; $display("FAIL rx_ovr_clear: got %b want 0", d[CON_RX_OVR]); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic [7:0]  a, b;
    int n;
    tx_log.delete();
    uart_hang = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    bus_write(UART_TXD, 32'(a));
    bus_write(UART_TXD, 32'(b));
    tests_run++; if (uart_tx_enable !== 1'b1 || uart_tx_data !== a) begin tests_failed++; $display("FAIL tmo_first_launch: got en=%b data=%h want 1/%h", uart_tx_enable, uart_tx_data, a); end
    n = 0;
    do begin
      tick(); n++;
      if (n == 1000) begin
        peek(UART_CON, d);
        tests_run++; if (d[CON_TX_TMO] !== 1'b0 || d[CON_TX_BUSY] !== 1'b1) begin tests_failed++; $display("FAIL tmo_early: got tmo=%b busy=%b want 0/1", d[CON_TX_TMO], d[CON_TX_BUSY]); end
      end
    end while (uart_tx_enable !== 1'b1 && n < 3000);
    tests_run++; if (n != TMO + 3) begin tests_failed++; $display("FAIL tmo_gap: got %0d cycles want %0d", n, TMO + 3); end
    peek(UART_CON, d);
    tests_run++; if (d[CON_TX_TMO] !== 1'b1) begin tests_failed++; $display("FAIL tmo_flag: got %b want 1", d[CON_TX_TMO]); end
    tests_run++; if (uart_tx_data !== b) begin tests_failed++; $display("FAIL tmo_next_byte: got %h want %h", uart_tx_data, b); end
    bus_write(UART_CON, 32'h80);
    peek(UART_CON, d);
    tests_run++; if (d[CON_TX_TMO] !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear: got %b want 0", d[CON_TX_TMO]); end
    n = 0;
    peek(UART_CON, d);
    while (d[CON_TX_BUSY] === 1'b1 && n < 3000) begin tick(); n++; peek(UART_CON, d); end
    tests_run++; if (d[CON_TX_BUSY] !== 1'b0 || d[CON_TX_TMO] !== 1'b1) begin tests_failed++; $display("FAIL tmo_second: got busy=%b tmo=%b want 0/1", d[CON_TX_BUSY], d[CON_TX_TMO]); end
    bus_write(UART_CON, 32'h80);
    uart_hang = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0]  b;
    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_q [$];
    bit          ovr_exp;
    int          n, bad;
    tx_log.delete();
    ovr_exp = 1'b0;
    fall_dly = int'($urandom_range(2, 10));
    busy_dly = int'($urandom_range(5, 30));
    bus_write(UART_CON, 32'hE0);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          peek(UART_CON, d);
          if (d[CON_TX_FULL] === 1'b0) begin
            b = 8'($urandom);
            bus_write(UART_TXD, 32'(b));
            tx_exp.push_back(b);
          end
        end
        1: begin
          b = 8'($urandom);
          rx_deliver(b, int'($urandom_range(20, 40)));
          if (rx_q.size() < RXD_N) rx_q.push_back(b); else ovr_exp = 1'b1;
        end
        2: begin
          exp = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
          bus_read(UART_RXD, d);
          tests_run++; if (d !== exp) begin tests_failed++; $display("FAIL rnd_rx_read%0d: got %h want %h", i, d, exp); end
        end
        default: tick(int'($urandom_range(1, 20)));
      endcase
    end
    peek(UART_CON, d);
    tests_run++; if (d[CON_RX_OVR] !== ovr_exp || d[CON_RX_NE] !== (rx_q.size() != 0)) begin tests_failed++; $display("FAIL rnd_rx_status: got ovr=%b ne=%b want %b/%b", d[CON_RX_OVR], d[CON_RX_NE], ovr_exp, rx_q.size() != 0); end
    while (rx_q.size() != 0) begin
      exp = {24'b0, rx_q.pop_front()};
      bus_read(UART_RXD, d);
      tests_run++; if (d !== exp) begin tests_failed++; $display("FAIL rnd_rx_drain: got %h want %h", d, exp); end
    end
    n = 0;
    peek(UART_CON, d);
    while ((tx_log.size() < tx_exp.size() || d[CON_TX_BUSY] === 1'b1) && n < 5000) begin tick(); n++; peek(UART_CON, d); end
    bad = 0;
    for (int i = 0; i < tx_exp.size() && i < tx_log.size(); i++) if (tx_log[i] !== tx_exp[i]) bad++;
    tests_run++; if (bad != 0 || tx_log.size() != tx_exp.size()) begin tests_failed++; $display("FAIL rnd_tx_stream: got %0d bytes (%0d wrong) want %0d", tx_log.size(), bad, tx_exp.size()); end
    bus_write(UART_CON, 32'hE0);
  endtask

  task automatic test_irq_reset();
    logic [31:0] d;
    int n;
    bus_write(UART_CON, 32'h02);
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_idle: got %b want 0", irq); end
    uart_rx_data = 8'($urandom); uart_rx_status = 1'b1;
    n = 0;
    peek(UART_CON, d);
    while (d[CON_RX_NE] !== 1'b1 && n < 10) begin tick(); n++; peek(UART_CON, d); end
    tests_run++; if (d[CON_RX_NE] !== 1'b1 || irq !== 1'b0) begin tests_failed++; $display("FAIL irq_at_push: got ne=%b irq=%b want 1/0", d[CON_RX_NE], irq); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_after_push: got %b want 1", irq); end
    tick(30);
    uart_rx_status = 1'b0;
    tick(8);
    tx_log.delete();
    fall_dly = 5; busy_dly = 500;
    bus_write(UART_TXD, 32'($urandom_range(0, 255)));
    bus_write(UART_TXD, 32'($urandom_range(0, 255)));
    n = 0;
    while (uart_tx_status !== 1'b0 && n < 50) begin tick(); n++; end
    tick(10);
    peek(UART_CON, d);
    tests_run++; if (d[CON_TX_BUSY] !== 1'b1 || irq !== 1'b1) begin tests_failed++; $display("FAIL pre_reset: got busy=%b irq=%b want 1/1", d[CON_TX_BUSY], irq); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (irq !== 1'b0 || uart_tx_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_irq: got irq=%b en=%b want 0/0", irq, uart_tx_enable); end
    peek(UART_CON, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_mid_con: got %h want 0", d); end
    peek(UART_RXD, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_mid_rxd: got %h want 0", d); end
    tick(2);
    reset_n = 1'b1;
    n = 0;
    while (uart_active && n < 1000) begin tick(); n++; end
    tick(5);
    peek(UART_CON, d);
    tests_run++; if (d !== 32'h0 || tx_log.size() != 1) begin tests_failed++; $display("FAIL post_reset_idle: got con=%h launches=%0d want 0/1", d, tx_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_tx_overflow();
    test_rx();
    test_rx_overrun();
    test_timeout();
    test_random_traffic();
    test_irq_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
